// File: rtl/control_unit.sv
// Instruction decoder and program counter for the 8-bit CPU.
// Defining CTRL_LOADI_EN compiles in the LOADI (inst[7]=1) decode.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inst,
  output logic [7:0] memAddr,
  output logic [2:0] aluSel,
  output logic [2:0] regInSel,
  output logic [2:0] regOutSel,
  output logic       regInEn,
  output logic       regOutEn,
  output logic       genConst
);

  localparam logic [7:0] InstHalt = 8'b00011_111;

  logic [7:0] pc_q, pc_d;
  logic       halted_q, halted_d;
  logic [2:0] alu_sel, reg_in_sel, reg_out_sel;
  logic       reg_in_en, reg_out_en;
  logic       active;

  assign active = rst && !halted_q;

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (!rst) begin
      pc_d     = 8'h00;
      halted_d = 1'b0;
    end else if (!halted_q) begin
      // HALT leaves the PC pointing at itself.
      if (inst == InstHalt) begin
        halted_d = 1'b1;
      end else begin
        pc_d = pc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    halted_q <= halted_d;
  end

`ifdef CTRL_LOADI_EN
  logic gen_const;
`endif

  always_comb begin
    alu_sel     = 3'b000;
    reg_in_sel  = 3'b000;
    reg_out_sel = 3'b000;
    reg_in_en   = 1'b0;
    reg_out_en  = 1'b0;
`ifdef CTRL_LOADI_EN
    gen_const   = 1'b0;
`endif
    if (active) begin
      if (inst[7]) begin
`ifdef CTRL_LOADI_EN
        gen_const  = 1'b1;
        reg_in_en  = 1'b1;
        reg_in_sel = inst[2:0];
`endif
      end else if (inst[6]) begin
        alu_sel     = inst[5:3];
        reg_out_sel = inst[2:0];
        reg_out_en  = 1'b1;
        reg_in_en   = 1'b1;
      end else begin
        case (inst[5:3])
          3'b001: begin
            reg_out_sel = inst[2:0];
            reg_out_en  = 1'b1;
            reg_in_en   = 1'b1;
          end
          3'b010: begin
            reg_in_sel = inst[2:0];
            reg_out_en = 1'b1;
            reg_in_en  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign memAddr   = rst ? pc_q : 8'h00;
  assign aluSel    = alu_sel;
  assign regInSel  = reg_in_sel;
  assign regOutSel = reg_out_sel;
  assign regInEn   = reg_in_en;
  assign regOutEn  = reg_out_en;
`ifdef CTRL_LOADI_EN
  assign genConst  = gen_const;
`else
  assign genConst  = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; decode outputs are checked as one
// packed vector {aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst}.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] inst;
  logic [7:0] memAddr;
  logic [2:0] aluSel, regInSel, regOutSel;
  logic       regInEn, regOutEn, genConst;

  int n_pass;
  int n_total;
  logic [7:0] exp_pc;

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .inst     (inst),
    .memAddr  (memAddr),
    .aluSel   (aluSel),
    .regInSel (regInSel),
    .regOutSel(regOutSel),
    .regInEn  (regInEn),
    .regOutEn (regOutEn),
    .genConst (genConst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] dec_vec();
    return {aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst};
  endfunction

  task automatic chk_dec(input string tag, input logic [11:0] exp);
    logic [11:0] got;
    #1;
    got = dec_vec();
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: decode got %b expected %b", tag, got, exp);
  endtask

  task automatic chk_pc(input string tag, input logic [7:0] exp);
    #1;
    n_total++;
    assert (memAddr === exp) n_pass++;
    else $error("FAIL %s: memAddr got %h expected %h", tag, memAddr, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst  = 1'b0;
    inst = 8'hFF;
    chk_dec("rst_dec", 12'b000_000_000_0_0_0);
    chk_pc("rst_pc_pre", 8'h00);
    step();
    chk_pc("rst_pc", 8'h00);

    rst  = 1'b1;
    inst = 8'h00;
    chk_dec("nop", 12'b000_000_000_0_0_0);
    chk_pc("release_pc", 8'h00);
    step();
    chk_pc("first_inc", 8'h01);
    step();
    chk_pc("second_inc", 8'h02);
    exp_pc = 8'h02;

    inst = 8'b00001_011;
    chk_dec("mov_r0_rr", 12'b000_000_011_1_1_0);
    inst = 8'b01101_010;
    chk_dec("alu", 12'b101_000_010_1_1_0);
    inst = 8'b00010_110;
    chk_dec("mov_rr_r0", 12'b000_110_000_1_1_0);
    inst = 8'b00011_010;
    chk_dec("rsvd_0001", 12'b000_000_000_0_0_0);
    inst = 8'b00101_000;
    chk_dec("rsvd_001", 12'b000_000_000_0_0_0);
    inst = 8'b1_1010_100;
`ifdef CTRL_LOADI_EN
    chk_dec("loadi", 12'b000_100_000_1_0_1);
`else
    chk_dec("loadi_off", 12'b000_000_000_0_0_0);
`endif

    inst = 8'h00;
    while (exp_pc != 8'hFF) begin
      step();
      exp_pc = exp_pc + 8'd1;
    end
    chk_pc("pc_ff", 8'hFF);
    step();
    chk_pc("wrap", 8'h00);
    step();
    chk_pc("post_wrap", 8'h01);

    inst = 8'b00011_111;
    chk_dec("halt_dec", 12'b000_000_000_0_0_0);
    step();
    chk_pc("halt_hold", 8'h01);
    inst = 8'b00001_001;
    chk_dec("halted_dec", 12'b000_000_000_0_0_0);
    step();
    chk_pc("halted_hold", 8'h01);
    step();
    chk_pc("halted_hold2", 8'h01);

    rst = 1'b0;
    chk_pc("rst_force", 8'h00);
    step();
    rst = 1'b1;
    chk_dec("unhalted_dec", 12'b000_000_001_1_1_0);
    chk_pc("unhalted_pc", 8'h00);
    step();
    chk_pc("unhalted_inc", 8'h01);

    inst = 8'b01101_010;
    rst  = 1'b0;
    chk_dec("rst_mid_dec", 12'b000_000_000_0_0_0);
    chk_pc("rst_mid_pc", 8'h00);
    step();
    rst  = 1'b1;
    inst = 8'b00011_111;
    chk_pc("halt_release_pc", 8'h00);
    step();
    chk_pc("halt_release_hold", 8'h00);
    inst = 8'b00001_011;
    chk_dec("halt_release_dec", 12'b000_000_000_0_0_0);
    step();
    chk_pc("halt_release_hold2", 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
